// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: sends a captured pattern MSB-first on a serial line.
// Optional macro SERIAL_PATTERN_GEN_REPEAT_EN sends it rep+1 times.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      transfer request, sampled only while idle
//   pat        pattern; bit len-1 goes out first
//   len        pattern length 1..PAT_W (0 ignored, larger clamped)
//   rep        extra repetitions (repeat build only)
//   data_out   serial bit
//   data_valid high while data_out carries a pattern bit
//   busy       high from the cycle after start until done
//   done       one-cycle pulse after the last bit
module serial_pattern_gen #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat,
    input  logic [3:0]       len,
    input  logic [3:0]       rep,
    output logic             data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [3:0] LEN_MAX = 4'(PAT_W);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       len_eff;
    logic [PAT_W-1:0] pat_sh;

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    logic [3:0] len_q, len_d;
    logic [3:0] rep_q, rep_d;
`else
    logic unused_rep;
    assign unused_rep = ^rep;
`endif

    assign len_eff = (len > LEN_MAX) ? LEN_MAX : len;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
        len_d   = len_q;
        rep_d   = rep_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && (len != 4'd0)) begin
                    state_d = SHIFT;
                    pat_d   = pat;
                    cnt_d   = len_eff - 4'd1;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
                    len_d   = len_eff;
                    rep_d   = rep;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == 4'd0) begin
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
                    // Reload the bit index for the next copy, no gap cycle.
                    if (rep_q != 4'd0) begin
                        cnt_d = len_q - 4'd1;
                        rep_d = rep_q - 4'd1;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= 4'd0;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
            len_q   <= 4'd0;
            rep_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
            len_q   <= len_d;
            rep_q   <= rep_d;
`endif
        end
    end

    // The counter doubles as the index of the bit currently on the line.
    assign pat_sh     = pat_q >> cnt_q;
    assign data_valid = (state_q == SHIFT);
    assign data_out   = (state_q == SHIFT) && pat_sh[0];
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: queue-based reference model plus directed
// literal checks and randomized traffic for serial_pattern_gen.
module tb_serial_pattern_gen;

    localparam int PAT_W = 8;

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pat = '0;
    logic [3:0]       len = 4'd0;
    logic [3:0]       rep = 4'd0;
    logic             data_out;
    logic             data_valid;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    // {data_out, data_valid, busy, done}
    typedef logic [3:0] obs_t;
    obs_t cur = 4'b0000;
    obs_t q[$];

    always #5 clk = ~clk;

    serial_pattern_gen #(.PAT_W(PAT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pat        (pat),
        .len        (len),
        .rep        (rep),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a transfer is the list of expected cycles it produces.
    always @(posedge clk or negedge rst) begin : model
        int n;
        int reps;
        if (!rst) begin
            q.delete();
            cur = 4'b0000;
        end else begin
            if (!cur[1] && start && len != 4'd0) begin
                n    = (int'(len) > PAT_W) ? PAT_W : int'(len);
                reps = REP_EN ? int'(rep) + 1 : 1;
                for (int r = 0; r < reps; r++)
                    for (int i = n - 1; i >= 0; i--)
                        q.push_back({pat[i], 1'b1, 1'b1, 1'b0});
                q.push_back(4'b0011);
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur = 4'b0000;
        end
    end

    always @(negedge clk) begin
        check("model", {28'd0, data_out, data_valid, busy, done},
              {28'd0, cur});
    end

    task automatic go(input logic [7:0] p, input logic [3:0] l,
                      input logic [3:0] r);
        @(negedge clk);
        pat = p; len = l; rep = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bit k of each word is the value seen in cycle k+1 after start.
    task automatic grab(input int n, output logic [31:0] d,
                        output logic [31:0] v, output logic [31:0] dn,
                        output logic [31:0] b);
        d = '0; v = '0; dn = '0; b = '0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            d[k] = data_out; v[k] = data_valid;
            dn[k] = done; b[k] = busy;
        end
    endtask

    initial begin : stim
        logic [31:0] d, v, dn, b;

        #1;
        check("reset_out", {28'd0, data_out, data_valid, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_out", {28'd0, data_out, data_valid, busy, done}, 32'd0);

        go(8'h0B, 4'd4, 4'd0);
        grab(6, d, v, dn, b);
        check("p0B_data", d, 32'h0D);
        check("p0B_valid", v, 32'h0F);
        check("p0B_done", dn, 32'h10);
        check("p0B_busy", b, 32'h1F);

        go(8'hA5, 4'd8, 4'd0);
        grab(10, d, v, dn, b);
        check("pA5_data", d, 32'h0A5);
        check("pA5_valid", v, 32'h0FF);
        check("pA5_done", dn, 32'h100);

        go(8'hFF, 4'd0, 4'd0);
        grab(4, d, v, dn, b);
        check("len0_busy", b, 32'h0);
        check("len0_valid", v, 32'h0);

        go(8'hFF, 4'd12, 4'd0);
        grab(10, d, v, dn, b);
        check("len12_ones", 32'($countones(d & v)), 32'd8);
        check("len12_valid", v, 32'h0FF);
        check("len12_done", dn, 32'h100);

        // Re-pulse start and change inputs in cycle 2.
        go(8'h0B, 4'd4, 4'd0);
        d = '0; v = '0; dn = '0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            d[k] = data_out; v[k] = data_valid; dn[k] = done;
            if (k == 1) begin
                start = 1'b1; pat = 8'hF0; len = 4'd8; rep = 4'd3;
            end
            if (k == 2) start = 1'b0;
        end
        check("restart_data", d, 32'h0D);
        check("restart_done", dn, 32'h10);

        // Asynchronous reset in cycle 3 of a long transfer.
        go(8'hA5, 4'd8, 4'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_rst", {28'd0, data_out, data_valid, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        go(8'h0B, 4'd4, 4'd0);
        grab(6, d, v, dn, b);
        check("post_rst_data", d, 32'h0D);
        check("post_rst_done", dn, 32'h10);

        go(8'h0B, 4'd4, 4'd2);
        grab(14, d, v, dn, b);
        if (REP_EN) begin
            check("rep_data", d, 32'h0DDD);
            check("rep_valid", v, 32'h0FFF);
            check("rep_done", dn, 32'h1000);
        end else begin
            check("rep_data", d, 32'h000D);
            check("rep_valid", v, 32'h000F);
            check("rep_done", dn, 32'h0010);
        end

        // Start held high: back-to-back transfers with one idle cycle.
        @(negedge clk);
        pat = 8'h0B; len = 4'd4; rep = 4'd0; start = 1'b1;
        @(negedge clk);
        grab(8, d, v, dn, b);
        check("held_done", dn, 32'h10);
        check("held_data", d, 32'h4D);
        start = 1'b0;
        repeat (12) @(negedge clk);

        for (int it = 0; it < 1500; it++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) pat = 8'($urandom);
            len = 4'($urandom_range(0, 15));
            rep = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                #1 check("rand_rst", {28'd0, data_out, data_valid, busy, done},
                         32'd0);
                #1 rst = 1'b1;
            end
        end
        start = 1'b0;
        repeat (80) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
SERIAL_PATTERN_GEN -- requirements
Module: serial_pattern_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning maximum pattern length in bits (2..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to transmit; sampled only in IDLE.
REQ-005 SHALL have port pat  input  PAT_W  pattern; bit len-1 is sent first, bit 0 last.
REQ-006 SHALL have port len  input  4  pattern length in bits; valid range 1..PAT_W.
REQ-007 SHALL have port rep  input  4  extra repetitions; used only with the repeat option.
REQ-008 SHALL have port data_out  output  1  serial bit, the stimulus stream for the 1011 detector.
REQ-009 SHALL have port data_valid  output  1  high while data_out carries a pattern bit.
REQ-010 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last bit.

Function
REQ-012 SHALL be a Moore FSM with states IDLE, SHIFT, DONE; all outputs are registered or decoded from state only.
REQ-013 In IDLE, start=1 with len in 1..PAT_W SHALL capture pat, len and rep, and go to SHIFT.
REQ-014 start with len=0 SHALL be ignored; len>PAT_W SHALL be clamped to PAT_W.
REQ-015 Latency SHALL be 1 cycle: the first bit, pat[len-1], appears on data_out in the cycle after the start sample.
REQ-016 SHIFT SHALL emit one bit per cycle MSB-first, from pat[len-1] to pat[0], with data_valid=1 and busy=1.
REQ-017 A bit counter SHALL count down from len-1; at zero, the FSM goes to DONE (or restarts the pattern, see REQ-023).
REQ-018 DONE SHALL last exactly 1 cycle with done=1, data_valid=0, busy=1, and data_out=0, then return to IDLE.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored; a start held high in IDLE after DONE SHALL begin a new transfer.
REQ-020 Changes to pat, len or rep during a transfer SHALL have no effect, because the captured copies are used.
REQ-021 In IDLE: data_out=0, data_valid=0, busy=0, done=0.

Reset
REQ-022 rst=0 SHALL immediately force state IDLE, counters to 0, and data_out, data_valid, busy and done to 0, including in the middle of a transfer; the first rising clk after rst returns to 1 samples start normally.

Configuration
REQ-023 With SERIAL_PATTERN_GEN_REPEAT_EN defined, the captured pattern SHALL be sent rep+1 times back-to-back with no gap cycles, and only one done pulse after the final bit.
REQ-024 Without SERIAL_PATTERN_GEN_REPEAT_EN, the rep port SHALL still exist but be ignored, and the pattern is sent exactly once.

Verification
REQ-025 pat=8'h0B, len=4, start pulse -> data_out 1,0,1,1 in cycles 1-4 with data_valid=1; done=1 in cycle 5; IDLE in cycle 6; the detector connected to the output asserts det.
REQ-026 pat=8'hA5, len=8 -> data_out 1,0,1,0,0,1,0,1 in 8 consecutive cycles, then a single done pulse.
REQ-027 len=0 with start=1 -> busy stays 0 and data_valid stays 0; len=12 with pat=8'hFF -> exactly 8 ones.
REQ-028 start re-pulsed at cycle 2 of a len=4 transfer, and pat changed at the same time -> output is unchanged and there is still only one done pulse.
REQ-029 rst driven low at cycle 3 of a len=8 transfer -> all outputs 0 immediately; after release, a new start with pat=8'h0B, len=4 gives 1,0,1,1.
REQ-030 With REPEAT_EN: pat=8'h0B, len=4, rep=2 -> 12 bits 1011 1011 1011 back-to-back, done in cycle 13; without REPEAT_EN, the same stimulus gives 4 bits and done in cycle 5.
